ritc_phase_scanner_interface_v3: RTL and testbench

RITC_PHASE_SCANNER_INTERFACE_V3 -- requirements
Module: ritc_phase_scanner_interface_v3

---
 rtl/ritc_scan_pkg.sv | 31 +++
 rtl/ritc_scan_result_fifo.sv | 50 +++++
 rtl/ritc_phase_scanner_interface_v3.sv | 170 +++++++++++++++++
 tb/tb_ritc_phase_scanner_interface_v3.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ritc_scan_pkg.sv
// Shared constants for the RITC phase scanner interface: register map,
// STATUS bit positions and command FSM state encoding.
package ritc_scan_pkg;

  localparam logic [3:0] A_CMD        = 4'd0;
  localparam logic [3:0] A_SEL_LO     = 4'd1;
  localparam logic [3:0] A_SEL_HI     = 4'd2;
  localparam logic [3:0] A_ARG_LO     = 4'd3;
  localparam logic [3:0] A_ARG_HI     = 4'd4;
  localparam logic [3:0] A_STATUS     = 4'd5;
  localparam logic [3:0] A_RES_LO     = 4'd6;
  localparam logic [3:0] A_RES_HI     = 4'd7;
  localparam logic [3:0] A_SERVO_LO   = 4'd8;
  localparam logic [3:0] A_SERVO_HI   = 4'd9;
  localparam logic [3:0] A_FIFO_COUNT = 4'd10;

  localparam int ST_BUSY  = 0;
  localparam int ST_DONE  = 1;
  localparam int ST_TMO   = 2;
  localparam int ST_REJ   = 3;
  localparam int ST_OVF   = 4;
  localparam int ST_SNEW  = 5;
  localparam int ST_EMPTY = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } scan_state_e;

endpackage

// File: rtl/ritc_scan_result_fifo.sv
// Result FIFO: a push while full is dropped unless a pop happens in the
// same cycle, in which case both proceed.
module ritc_scan_result_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          overflow_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);
  assign overflow_o = push_i && full_o && !do_pop;
  assign dout_o     = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/ritc_phase_scanner_interface_v3.sv
// Byte-register front end for the RITC phase scanner: command FSM, result
// FIFO, servo capture. Define RITC_SCAN_TIMEOUT_EN to enable the WAIT timeout.
module ritc_phase_scanner_interface_v3
  import ritc_scan_pkg::*;
#(
  parameter int NUM_CH         = 8,
  parameter int RES_DEPTH      = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              user_sel_i,
  input  logic [3:0]        user_addr_i,
  input  logic [7:0]        user_dat_i,
  output logic [7:0]        user_dat_o,
  input  logic              user_wr_i,
  input  logic              user_rd_i,
  output logic [NUM_CH-1:0] select_o,
  output logic [7:0]        cmd_o,
  output logic              cmd_wr_o,
  output logic [15:0]       argument_o,
  output logic              argument_wr_o,
  input  logic [15:0]       result_i,
  input  logic              result_valid_i,
  input  logic [15:0]       servo_i,
  input  logic              servo_update_i,
  output logic              busy_o,
  output logic [2:0]        debug_o
);

  localparam int AW = $clog2(RES_DEPTH);

  scan_state_e       state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [NUM_CH-1:0] sel_q, sel_d;
  logic [15:0]       arg_q, arg_d;
  logic              arg_wr_q;
  logic [15:0]       servo_q;
  logic [7:0]        shadow_q;
  logic [5:1]        stky_q, stky_d;
  logic [15:0]       sel_full, sel_wr;
  logic              wr_stb, rd_stb, cmd_wr, pop;
  logic              done_set, tmo_set, rej_set;
  logic [15:0]       fifo_head;
  logic [AW:0]       fifo_count;
  logic              fifo_full, fifo_empty, fifo_ovf;
  logic [7:0]        status;

  assign wr_stb = user_sel_i && user_wr_i;
  assign rd_stb = user_sel_i && user_rd_i;
  assign cmd_wr = wr_stb && (user_addr_i == A_CMD);
  assign pop    = rd_stb && (user_addr_i == A_RES_HI);

  ritc_scan_result_fifo #(.W(16), .DEPTH(RES_DEPTH)) u_fifo (
    .clk_i(CLK), .rst_i(RST), .push_i(result_valid_i), .pop_i(pop),
    .din_i(result_i), .dout_o(fifo_head), .count_o(fifo_count),
    .full_o(fifo_full), .empty_o(fifo_empty), .overflow_o(fifo_ovf)
  );

  // Select held as NUM_CH bits; widened to 16 so byte lanes above NUM_CH read 0.
  always_comb begin
    sel_full = '0;
    sel_full[NUM_CH-1:0] = sel_q;
    sel_wr = sel_full;
    if (wr_stb && user_addr_i == A_SEL_LO) sel_wr[7:0]  = user_dat_i;
    if (wr_stb && user_addr_i == A_SEL_HI) sel_wr[15:8] = user_dat_i;
    sel_d = sel_wr[NUM_CH-1:0];
  end

  always_comb begin
    arg_d = arg_q;
    if (wr_stb && user_addr_i == A_ARG_LO) arg_d[7:0]  = user_dat_i;
    if (wr_stb && user_addr_i == A_ARG_HI) arg_d[15:8] = user_dat_i;
  end

`ifdef RITC_SCAN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q;
  logic          tmo_hit;
  assign tmo_hit = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                    tmo_cnt_q <= '0;
    else if (state_q == S_ISSUE) tmo_cnt_q <= '0;
    else if (state_q == S_WAIT)  tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end
`else
  logic tmo_hit;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    done_set = 1'b0;
    tmo_set  = 1'b0;
    rej_set  = cmd_wr && (state_q != S_IDLE);
    case (state_q)
      S_IDLE:  if (cmd_wr) begin state_d = S_ISSUE; cmd_d = user_dat_i; end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // A result landing on the expiry cycle counts as completion.
        if (result_valid_i) begin state_d = S_IDLE; done_set = 1'b1; end
        else if (tmo_hit)   begin state_d = S_IDLE; tmo_set  = 1'b1; end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Set events are OR-ed after the read clear so they survive a coincident read.
  always_comb begin
    stky_d = (rd_stb && user_addr_i == A_STATUS) ? '0 : stky_q;
    if (done_set)       stky_d[ST_DONE] = 1'b1;
    if (tmo_set)        stky_d[ST_TMO]  = 1'b1;
    if (rej_set)        stky_d[ST_REJ]  = 1'b1;
    if (fifo_ovf)       stky_d[ST_OVF]  = 1'b1;
    if (servo_update_i) stky_d[ST_SNEW] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      sel_q    <= '0;
      arg_q    <= '0;
      arg_wr_q <= 1'b0;
      servo_q  <= '0;
      shadow_q <= '0;
      stky_q   <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      sel_q    <= sel_d;
      arg_q    <= arg_d;
      arg_wr_q <= wr_stb && (user_addr_i == A_ARG_HI);
      stky_q   <= stky_d;
      if (servo_update_i) servo_q <= servo_i;
      if (rd_stb && user_addr_i == A_SERVO_LO) shadow_q <= servo_q[15:8];
    end
  end

  assign status = {1'b0, fifo_empty, stky_q, busy_o};

  always_comb begin
    user_dat_o = 8'h00;
    case (user_addr_i)
      A_CMD:        user_dat_o = cmd_q;
      A_SEL_LO:     user_dat_o = sel_full[7:0];
      A_SEL_HI:     user_dat_o = sel_full[15:8];
      A_ARG_LO:     user_dat_o = arg_q[7:0];
      A_ARG_HI:     user_dat_o = arg_q[15:8];
      A_STATUS:     user_dat_o = status;
      A_RES_LO:     user_dat_o = fifo_empty ? 8'h00 : fifo_head[7:0];
      A_RES_HI:     user_dat_o = fifo_empty ? 8'h00 : fifo_head[15:8];
      A_SERVO_LO:   user_dat_o = servo_q[7:0];
      A_SERVO_HI:   user_dat_o = shadow_q;
      A_FIFO_COUNT: user_dat_o = 8'(fifo_count);
      default:      user_dat_o = 8'h00;
    endcase
  end

  assign select_o      = sel_q;
  assign cmd_o         = cmd_q;
  assign cmd_wr_o      = (state_q == S_ISSUE);
  assign argument_o    = arg_q;
  assign argument_wr_o = arg_wr_q;
  assign busy_o        = (state_q != S_IDLE);
  assign debug_o       = {fifo_empty, state_q};

endmodule

// File: tb/tb_ritc_phase_scanner_interface_v3.sv
// Directed self-checking bench for ritc_phase_scanner_interface_v3.
module tb_ritc_phase_scanner_interface_v3;

`ifdef RITC_SCAN_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 65535;
`endif

  logic        CLK = 1'b0, RST = 1'b1;
  logic        sel = 0, wr = 0, rd = 0;
  logic [3:0]  addr = 0;
  logic [7:0]  din = 0, dout;
  logic [7:0]  select_o, cmd_o;
  logic        cmd_wr_o, argument_wr_o, busy_o;
  logic [15:0] argument_o;
  logic [15:0] result = 0, servo = 0;
  logic        rvalid = 0, supd = 0;
  logic [2:0]  debug_o;

  int n_cmp = 0, n_err = 0;
  int cmd_pulses = 0, arg_pulses = 0;

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (cmd_wr_o) cmd_pulses++;
    if (argument_wr_o) arg_pulses++;
  end

  ritc_phase_scanner_interface_v3 #(.NUM_CH(8), .RES_DEPTH(8), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RST(RST), .user_sel_i(sel), .user_addr_i(addr), .user_dat_i(din),
    .user_dat_o(dout), .user_wr_i(wr), .user_rd_i(rd), .select_o(select_o),
    .cmd_o(cmd_o), .cmd_wr_o(cmd_wr_o), .argument_o(argument_o),
    .argument_wr_o(argument_wr_o), .result_i(result), .result_valid_i(rvalid),
    .servo_i(servo), .servo_update_i(supd), .busy_o(busy_o), .debug_o(debug_o)
  );

  task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge CLK); sel = 1; wr = 1; addr = a; din = d;
    @(posedge CLK); #1; sel = 0; wr = 0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge CLK); sel = 1; rd = 1; addr = a;
    #1 d = dout;
    @(posedge CLK); #1; sel = 0; rd = 0;
  endtask

  task automatic push_res(input logic [15:0] v);
    @(negedge CLK); result = v; rvalid = 1;
    @(posedge CLK); #1; rvalid = 0;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    RST = 1;
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++; if ({select_o, cmd_o, argument_o} !== 32'h0) begin n_err++; $display("FAIL reset_outs: got %h want 0", {select_o, cmd_o, argument_o}); end
    n_cmp++; if ({cmd_wr_o, argument_wr_o, busy_o, debug_o} !== 6'b000100) begin n_err++; $display("FAIL reset_ctl: got %b want 000100", {cmd_wr_o, argument_wr_o, busy_o, debug_o}); end
    @(negedge CLK); RST = 0;
    bus_rd(4'd5, d);
    n_cmp++; if (d !== 8'h40) begin n_err++; $display("FAIL reset_status: got %h want 40", d); end
  endtask

  task automatic test_select;
    logic [7:0] d;
    bus_wr(4'd1, 8'hA5);
    bus_wr(4'd2, 8'hFF);
    n_cmp++; if (select_o !== 8'hA5) begin n_err++; $display("FAIL sel_out: got %h want a5", select_o); end
    bus_rd(4'd2, d);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL sel_hi_read: got %h want 00", d); end
    bus_rd(4'd1, d);
    n_cmp++; if (d !== 8'hA5) begin n_err++; $display("FAIL sel_lo_read: got %h want a5", d); end
    bus_rd(4'd12, d);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL unmapped_read: got %h want 00", d); end
  endtask

  task automatic test_argument;
    int p0;
    p0 = arg_pulses;
    bus_wr(4'd3, 8'h34);
    n_cmp++; if (argument_wr_o !== 1'b0) begin n_err++; $display("FAIL arg_lo_nopulse: got %b want 0", argument_wr_o); end
    @(negedge CLK); sel = 1; wr = 1; addr = 4'd4; din = 8'h12;
    n_cmp++; if (argument_wr_o !== 1'b0) begin n_err++; $display("FAIL arg_pulse_early: got %b want 0", argument_wr_o); end
    @(posedge CLK); #1; sel = 0; wr = 0;
    n_cmp++; if (argument_wr_o !== 1'b1 || argument_o !== 16'h1234) begin n_err++; $display("FAIL arg_pulse: got %b/%h want 1/1234", argument_wr_o, argument_o); end
    repeat (3) @(posedge CLK);
    #1;
    n_cmp++; if (arg_pulses - p0 !== 1) begin n_err++; $display("FAIL arg_pulse_count: got %0d want 1", arg_pulses - p0); end
  endtask

  task automatic test_command;
    logic [7:0] d;
    int p0;
    p0 = cmd_pulses;
    bus_wr(4'd0, 8'h05);
    n_cmp++; if (cmd_o !== 8'h05 || cmd_wr_o !== 1'b1 || busy_o !== 1'b1) begin n_err++; $display("FAIL cmd_issue: got %h/%b/%b want 05/1/1", cmd_o, cmd_wr_o, busy_o); end
    repeat (3) @(posedge CLK);
    #1;
    n_cmp++; if (cmd_pulses - p0 !== 1 || debug_o !== 3'b110) begin n_err++; $display("FAIL cmd_wait: got pulses %0d dbg %b want 1/110", cmd_pulses - p0, debug_o); end
    push_res(16'hBEEF);
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL cmd_done_busy: got %b want 0", busy_o); end
    bus_rd(4'd5, d);
    n_cmp++; if (d !== 8'h02) begin n_err++; $display("FAIL status_done: got %h want 02", d); end
    bus_rd(4'd6, d);
    n_cmp++; if (d !== 8'hEF) begin n_err++; $display("FAIL res_lo: got %h want ef", d); end
    bus_rd(4'd7, d);
    n_cmp++; if (d !== 8'hBE) begin n_err++; $display("FAIL res_hi: got %h want be", d); end
    bus_rd(4'd5, d);
    n_cmp++; if (d !== 8'h40) begin n_err++; $display("FAIL status_clear: got %h want 40", d); end
  endtask

  task automatic test_overflow;
    logic [7:0] d, lo, hi;
    logic [15:0] exp;
    for (int i = 0; i < 9; i++) push_res(16'h1000 + 16'(i));
    bus_rd(4'd10, d);
    n_cmp++; if (d !== 8'd8) begin n_err++; $display("FAIL ovf_count: got %0d want 8", d); end
    bus_rd(4'd5, d);
    n_cmp++; if (d !== 8'h10) begin n_err++; $display("FAIL ovf_status: got %h want 10", d); end
    // full FIFO: push and pop in the same cycle
    @(negedge CLK); sel = 1; rd = 1; addr = 4'd7; result = 16'h2222; rvalid = 1;
    #1 d = dout;
    @(posedge CLK); #1; sel = 0; rd = 0; rvalid = 0;
    n_cmp++; if (d !== 8'h10) begin n_err++; $display("FAIL full_pushpop_data: got %h want 10", d); end
    bus_rd(4'd5, d);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL full_pushpop_status: got %h want 00", d); end
    for (int i = 0; i < 8; i++) begin
      exp = (i < 7) ? 16'h1001 + 16'(i) : 16'h2222;
      bus_rd(4'd6, lo);
      bus_rd(4'd7, hi);
      n_cmp++; if ({hi, lo} !== exp) begin n_err++; $display("FAIL pop_%0d: got %h want %h", i, {hi, lo}, exp); end
    end
    bus_rd(4'd7, d);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL empty_pop: got %h want 00", d); end
    bus_rd(4'd10, d);
    n_cmp++; if (d !== 8'd0) begin n_err++; $display("FAIL drain_count: got %0d want 0", d); end
  endtask

  task automatic test_servo;
    logic [7:0] d;
    @(negedge CLK); servo = 16'hA55A; supd = 1;
    @(posedge CLK); #1; supd = 0;
    bus_rd(4'd8, d);
    n_cmp++; if (d !== 8'h5A) begin n_err++; $display("FAIL servo_lo: got %h want 5a", d); end
    // STATUS read coincident with a servo update keeps SERVO_NEW
    @(negedge CLK); sel = 1; rd = 1; addr = 4'd5; servo = 16'h1234; supd = 1;
    #1 d = dout;
    @(posedge CLK); #1; sel = 0; rd = 0; supd = 0;
    n_cmp++; if (d !== 8'h60) begin n_err++; $display("FAIL servo_status: got %h want 60", d); end
    bus_rd(4'd9, d);
    n_cmp++; if (d !== 8'hA5) begin n_err++; $display("FAIL servo_hi_shadow: got %h want a5", d); end
    bus_rd(4'd5, d);
    n_cmp++; if (d !== 8'h60) begin n_err++; $display("FAIL status_set_wins: got %h want 60", d); end
    bus_rd(4'd5, d);
    n_cmp++; if (d !== 8'h40) begin n_err++; $display("FAIL status_clear2: got %h want 40", d); end
  endtask

`ifdef RITC_SCAN_TIMEOUT_EN
  task automatic test_timeout;
    logic [7:0] d;
    int n, p0;
    p0 = cmd_pulses;
    n = 0;
    bus_wr(4'd0, 8'h03);
    while (busy_o && n < 100) begin @(posedge CLK); #1; n++; end
    n_cmp++; if (n !== 17) begin n_err++; $display("FAIL timeout_cycles: got %0d want 17", n); end
    bus_rd(4'd5, d);
    n_cmp++; if (d !== 8'h44 || cmd_pulses - p0 !== 1) begin n_err++; $display("FAIL timeout_status: got %h/%0d want 44/1", d, cmd_pulses - p0); end
  endtask
`endif

  task automatic test_reject;
    logic [7:0] d;
    int p0;
    push_res(16'h0001);
    push_res(16'h0002);
    p0 = cmd_pulses;
    bus_wr(4'd0, 8'h07);
    repeat (2) @(posedge CLK);
    bus_wr(4'd0, 8'h09);
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++; if (cmd_o !== 8'h07 || cmd_pulses - p0 !== 1) begin n_err++; $display("FAIL reject_cmd: got %h/%0d want 07/1", cmd_o, cmd_pulses - p0); end
    bus_rd(4'd5, d);
    n_cmp++; if (d !== 8'h09) begin n_err++; $display("FAIL reject_status: got %h want 09", d); end
`ifndef RITC_SCAN_TIMEOUT_EN
    repeat (40) @(posedge CLK);
    bus_rd(4'd5, d);
    n_cmp++; if (d !== 8'h01) begin n_err++; $display("FAIL wait_persist: got %h want 01", d); end
`endif
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    int p0;
    @(negedge CLK); #2 RST = 1;
    #1;
    n_cmp++; if ({select_o, cmd_o, argument_o} !== 32'h0 || {cmd_wr_o, argument_wr_o, busy_o} !== 3'b000) begin n_err++; $display("FAIL midreset_outs: got %h/%b want 0/000", {select_o, cmd_o, argument_o}, {cmd_wr_o, argument_wr_o, busy_o}); end
    @(negedge CLK); RST = 0;
    p0 = cmd_pulses;
    bus_rd(4'd10, d);
    n_cmp++; if (d !== 8'd0) begin n_err++; $display("FAIL midreset_count: got %0d want 0", d); end
    repeat (10) @(posedge CLK);
    #1;
    n_cmp++; if (cmd_pulses - p0 !== 0 || busy_o !== 1'b0) begin n_err++; $display("FAIL midreset_nopulse: got %0d/%b want 0/0", cmd_pulses - p0, busy_o); end
  endtask

  initial begin
    test_reset();
    test_select();
    test_argument();
    test_command();
    test_overflow();
    test_servo();
`ifdef RITC_SCAN_TIMEOUT_EN
    test_timeout();
`endif
    test_reject();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
